// File: rtl/taglist_player.sv
// Tag-list playback engine: fetches tag entries from the tag RAM read port and
// walks the sample-ROM address across each entry's [start, end] range.
module taglist_player #(
    parameter int unsigned RAM_LAT = 1,
    parameter int unsigned IDX_W   = 7,
    parameter int unsigned ROM_AW  = 10
) (
    input  logic              clk_1KHz,
    input  logic              reset_n,
    input  logic              start,
    input  logic [IDX_W-1:0]  start_idx,
    input  logic              abort,
    input  logic              step_en,
    output logic [IDX_W-1:0]  rd_addr,
    input  logic [31:0]       rd_data,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_valid,
    output logic [IDX_W-1:0]  cur_seq,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        PLAY  = 2'd3
    } state_t;

    state_t              state, state_n;
    logic [IDX_W-1:0]    idx, idx_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [ROM_AW-1:0]   rom_addr_n, end_r, end_n;
    logic                last_r, last_n;
    logic [IDX_W-1:0]    cur_seq_n;
    logic                rom_valid_n, busy_n, done_n, err_n;

    // Tag fields
    logic [IDX_W-1:0]    f_seq;
    logic [ROM_AW-1:0]   f_start, f_end;
    logic                f_last;
    logic                unused_bits;

    assign f_seq       = rd_data[21 +: IDX_W];
    assign f_start     = rd_data[11 +: ROM_AW];
    assign f_end       = rd_data[1 +: ROM_AW];
    assign f_last      = rd_data[0];
    assign unused_bits = ^rd_data[31:28];

    assign rd_addr = idx;

    // State and datapath registers
    always_ff @(posedge clk_1KHz or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            rom_addr  <= '0;
            end_r     <= '0;
            last_r    <= 1'b0;
            cur_seq   <= '0;
            rom_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            cnt       <= cnt_n;
            rom_addr  <= rom_addr_n;
            end_r     <= end_n;
            last_r    <= last_n;
            cur_seq   <= cur_seq_n;
            rom_valid <= rom_valid_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        cnt_n      = cnt;
        rom_addr_n = rom_addr;
        end_n      = end_r;
        last_n     = last_r;
        cur_seq_n  = cur_seq;
        err_n      = err;
        done_n     = 1'b0;

        if (abort) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx_n   = start_idx;
                        err_n   = 1'b0;
                        cnt_n   = '0;
                        state_n = FETCH;
                    end
                end
                FETCH: begin
                    if (cnt == CNT_W'(RAM_LAT - 1)) begin
                        cnt_n   = '0;
                        state_n = LOAD;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                LOAD: begin
                    cur_seq_n  = f_seq;
                    rom_addr_n = f_start;
                    end_n      = f_end;
                    last_n     = f_last;
                    if (f_start > f_end) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = PLAY;
                    end
                end
                PLAY: begin
                    if (step_en) begin
                        if (rom_addr < end_r) begin
                            rom_addr_n = rom_addr + ROM_AW'(1);
                        end else if (last_r) begin
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end else if (idx == {IDX_W{1'b1}}) begin
                            // Running off the end of the tag RAM is an error, not a wrap.
                            err_n   = 1'b1;
                            state_n = IDLE;
                        end else begin
                            idx_n   = idx + IDX_W'(1);
                            state_n = FETCH;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        rom_valid_n = (state_n == PLAY);
        busy_n      = (state_n != IDLE);
    end

endmodule

// File: tb/tb_taglist_player.sv
// Directed bench for taglist_player: table of playback scenarios plus
// hand-written abort and asynchronous reset sequences.
module tb_taglist_player;

    localparam int RAM_LAT = 1;
    localparam int BUDGET  = 400;

    logic        clk_1KHz = 1'b0;
    logic        reset_n;
    logic        start;
    logic [6:0]  start_idx;
    logic        abort;
    logic        step_en;
    logic [6:0]  rd_addr;
    logic [31:0] rd_data;
    logic [9:0]  rom_addr;
    logic        rom_valid;
    logic [6:0]  cur_seq;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk_1KHz = ~clk_1KHz;

    taglist_player #(.RAM_LAT(RAM_LAT), .IDX_W(7), .ROM_AW(10)) dut (
        .clk_1KHz  (clk_1KHz),
        .reset_n   (reset_n),
        .start     (start),
        .start_idx (start_idx),
        .abort     (abort),
        .step_en   (step_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rom_addr  (rom_addr),
        .rom_valid (rom_valid),
        .cur_seq   (cur_seq),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Tag RAM read port with RAM_LAT cycles of latency
    logic [31:0] ram  [128];
    logic [31:0] pipe [RAM_LAT];

    always @(posedge clk_1KHz) begin
        pipe[0] <= ram[rd_addr];
        for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign rd_data = pipe[RAM_LAT-1];

    function automatic logic [31:0] mk(input int seq, input int s, input int e, input int last);
        return {4'b0000, 7'(seq), 10'(s), 10'(e), 1'(last)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int timeout;
        int first_k;
        int nsamp;
        int first_addr;
        int last_addr;
        int valid_cyc;
        int idle_busy;
        int done_cnt;
        int gap_bad;
        int hold_bad;
        int err;
        int seq;
        int rd;
    } stats_t;

    typedef struct {
        int idx;
        int period;
        int mid;
        int first_k;
        int nsamp;
        int first_addr;
        int last_addr;
        int valid_cyc;
        int idle_busy;
        int done_cnt;
        int err;
        int seq;
        int rd;
    } vec_t;

    // Pulse start, pace step_en with the given period once PLAY can begin, and
    // record what the outputs did until busy falls.
    task automatic run(input int sidx, input int period, input int mid, output stats_t s);
        int k;
        int run_len;
        logic [9:0] prev;
        bit pv;
        s = '{default: 0};
        s.first_k = -1; s.first_addr = -1; s.last_addr = -1;
        pv = 1'b0; run_len = 0; prev = '0;
        @(negedge clk_1KHz);
        start = 1'b1; start_idx = 7'(sidx); step_en = 1'b0;
        @(negedge clk_1KHz);
        start = 1'b0;
        k = 1;
        forever begin
            if (k > BUDGET) begin
                s.timeout = 1;
                break;
            end
            if (done) s.done_cnt++;
            if (rom_valid) begin
                if (s.first_k < 0) s.first_k = k;
                s.valid_cyc++;
                if (pv && rom_addr == prev) begin
                    run_len++;
                end else begin
                    if (pv && run_len != period) s.hold_bad++;
                    if (s.nsamp > 0 && rom_addr != prev + 10'd1) s.gap_bad++;
                    if (s.first_addr < 0) s.first_addr = int'(rom_addr);
                    s.nsamp++;
                    run_len = 1;
                end
                prev = rom_addr;
                s.last_addr = int'(rom_addr);
                pv = 1'b1;
            end else begin
                if (pv && run_len != period) s.hold_bad++;
                pv = 1'b0;
                if (busy) s.idle_busy++;
            end
            if (!busy) break;
            step_en = (k >= RAM_LAT + 2) && (((k - (RAM_LAT + 2)) % period) == period - 1);
            start = (mid != 0) && (k == RAM_LAT + 4);
            start_idx = (mid != 0) ? 7'd20 : 7'(sidx);
            @(negedge clk_1KHz);
            k++;
        end
        step_en = 1'b0;
        start = 1'b0;
        s.err = int'(err);
        s.seq = int'(cur_seq);
        s.rd  = int'(rd_addr);
    endtask

    vec_t   vecs [8];
    stats_t st;
    int     wait_cnt;
    int     seen_done;

    initial begin
        for (int i = 0; i < 128; i++) ram[i] = '0;
        ram[0]   = mk(1, 12'h000, 12'h005, 0);
        ram[1]   = mk(2, 12'h006, 12'h00C, 0);
        ram[2]   = mk(3, 12'h00D, 12'h015, 0);
        ram[3]   = mk(4, 12'h016, 12'h02A, 0);
        ram[4]   = mk(5, 12'h02B, 12'h03F, 1);
        ram[10]  = mk(1, 12'h000, 12'h005, 1);
        ram[20]  = mk(9, 12'h010, 12'h008, 1);
        ram[30]  = mk(3, 12'h020, 12'h020, 1);
        ram[127] = mk(7, 12'h100, 12'h102, 0);
        ram[127][31:28] = 4'hF;

        //           idx  per mid fk nsamp first last  valid inv done err seq rd
        vecs[0] = '{  10,  1,  0, 3,   6,    0,    5,    6,  2,   1,  0,  1, 10};
        vecs[1] = '{  20,  1,  0,-1,   0,   -1,   -1,    0,  2,   0,  1,  9, 20};
        vecs[2] = '{  30,  1,  0, 3,   1,   32,   32,    1,  2,   1,  0,  3, 30};
        vecs[3] = '{   0,  1,  0, 3,  64,    0,   63,   64, 10,   1,  0,  5,  4};
        vecs[4] = '{   0,  1,  1, 3,  64,    0,   63,   64, 10,   1,  0,  5,  4};
        vecs[5] = '{  10,  4,  0, 3,   6,    0,    5,   24,  2,   1,  0,  1, 10};
        vecs[6] = '{  30,  4,  0, 3,   1,   32,   32,    4,  2,   1,  0,  3, 30};
        vecs[7] = '{ 127,  1,  0, 3,   3,  256,  258,    3,  2,   0,  1,  7,127};

        reset_n = 1'b0; start = 1'b0; start_idx = '0; abort = 1'b0; step_en = 1'b0;
        #1;
        chk("reset_busy",      int'(busy),      0);
        chk("reset_rom_valid", int'(rom_valid), 0);
        chk("reset_rom_addr",  int'(rom_addr),  0);
        chk("reset_rd_addr",   int'(rd_addr),   0);
        repeat (2) @(negedge clk_1KHz);
        reset_n = 1'b1;
        @(negedge clk_1KHz);
        chk("idle_done", int'(done), 0);
        chk("idle_err",  int'(err),  0);

        foreach (vecs[v]) begin
            run(vecs[v].idx, vecs[v].period, vecs[v].mid, st);
            chk($sformatf("v%0d_timeout", v),    st.timeout,    0);
            chk($sformatf("v%0d_first_k", v),    st.first_k,    vecs[v].first_k);
            chk($sformatf("v%0d_nsamp", v),      st.nsamp,      vecs[v].nsamp);
            chk($sformatf("v%0d_first_addr", v), st.first_addr, vecs[v].first_addr);
            chk($sformatf("v%0d_last_addr", v),  st.last_addr,  vecs[v].last_addr);
            chk($sformatf("v%0d_valid_cyc", v),  st.valid_cyc,  vecs[v].valid_cyc);
            chk($sformatf("v%0d_idle_busy", v),  st.idle_busy,  vecs[v].idle_busy);
            chk($sformatf("v%0d_done_cnt", v),   st.done_cnt,   vecs[v].done_cnt);
            chk($sformatf("v%0d_gap_bad", v),    st.gap_bad,    0);
            chk($sformatf("v%0d_hold_bad", v),   st.hold_bad,   0);
            chk($sformatf("v%0d_err", v),        st.err,        vecs[v].err);
            chk($sformatf("v%0d_seq", v),        st.seq,        vecs[v].seq);
            chk($sformatf("v%0d_rd_addr", v),    st.rd,         vecs[v].rd);
            repeat (2) @(negedge clk_1KHz);
        end

        // Abort during PLAY at rom_addr 3
        @(negedge clk_1KHz);
        start = 1'b1; start_idx = 7'd10;
        @(negedge clk_1KHz);
        start = 1'b0; step_en = 1'b1;
        wait_cnt = 0;
        seen_done = 0;
        while (!(rom_valid && rom_addr == 10'd3) && wait_cnt < 30) begin
            @(negedge clk_1KHz);
            wait_cnt++;
        end
        chk("abort_reach_addr3", int'(wait_cnt < 30), 1);
        abort = 1'b1;
        @(negedge clk_1KHz);
        abort = 1'b0;
        chk("abort_busy",      int'(busy),      0);
        chk("abort_rom_valid", int'(rom_valid), 0);
        chk("abort_cur_seq",   int'(cur_seq),   1);
        chk("abort_err",       int'(err),       0);
        repeat (8) begin
            if (done) seen_done++;
            @(negedge clk_1KHz);
        end
        step_en = 1'b0;
        chk("abort_no_done", seen_done, 0);
        chk("abort_stays_idle", int'(busy), 0);

        run(10, 1, 0, st);
        chk("replay_first_k",   st.first_k,   RAM_LAT + 2);
        chk("replay_nsamp",     st.nsamp,     6);
        chk("replay_first_addr", st.first_addr, 0);
        chk("replay_last_addr", st.last_addr, 5);
        chk("replay_done_cnt",  st.done_cnt,  1);

        // Asynchronous reset in the middle of FETCH, between clock edges
        repeat (2) @(negedge clk_1KHz);
        start = 1'b1; start_idx = 7'd10;
        @(negedge clk_1KHz);
        start = 1'b0;
        chk("fetch_busy",    int'(busy),    1);
        chk("fetch_rd_addr", int'(rd_addr), 10);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_busy",      int'(busy),      0);
        chk("async_rd_addr",   int'(rd_addr),   0);
        chk("async_rom_addr",  int'(rom_addr),  0);
        chk("async_cur_seq",   int'(cur_seq),   0);
        chk("async_rom_valid", int'(rom_valid), 0);
        chk("async_done",      int'(done),      0);
        chk("async_err",       int'(err),       0);
        @(negedge clk_1KHz);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_1KHz);
        chk("post_reset_idle", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
